// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit ends of the link.
//   rx_state_t     : receiver FSM state encoding
//   OVERSAMPLE_DEF : default sample_tick pulses per bit period
//   DATA_BITS_DEF  : default data bits per frame
//   PARITY_EVEN    : parity sense used by both transmitter and receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int   OVERSAMPLE_DEF = 16;
    localparam int   DATA_BITS_DEF  = 8;
    localparam logic PARITY_EVEN    = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Flops come out of reset at 1 so a reset never looks like a start bit.
//   clk : system clock
//   rst : synchronous, active-high reset
//   d   : asynchronous input (serial line)
//   q   : synchronized output
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage resynchronization chain, idle-high reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: recovers 8N1/8E1 frames from an oversampled serial line.
// Start bit is validated at mid-bit, data is shifted in LSB-first, even
// parity (optional) and the stop bit are checked. Each frame is presented
// with a one-cycle rx_valid strobe; flags qualify the frame and hold until
// the next strobe.
//   clk         : system clock
//   rst         : synchronous, active-high reset
//   sample_tick : one-clk pulse at OVERSAMPLE x baud
//   rx_serial   : asynchronous serial line, idle high
//   parity_en   : frame carries an even-parity bit (latched at start accept)
//   rx_data     : last received byte
//   rx_valid    : one-clk pulse when rx_data and flags are updated
//   parity_err  : last frame parity mismatch (0 when parity disabled)
//   frame_err   : last frame stop bit sampled 0
//   busy        : receiver is inside a frame or waiting out a break
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx_serial,
    input  logic                 parity_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Expected parity bit for a data word under the link's parity sense.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (^d) ^ ~PARITY_EVEN;
    endfunction

    logic                 rx_s;

    rx_state_t            state_r,      state_nxt;
    logic [SW-1:0]        sample_cnt_r, sample_cnt_nxt;
    logic [BW-1:0]        bit_cnt_r,    bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift_r,      shift_nxt;
    logic                 par_en_r,     par_en_nxt;
    logic                 perr_r,       perr_nxt;
    logic                 deliver_s;
    logic                 half_s;
    logic                 full_s;

    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 parity_err_r;
    logic                 frame_err_r;
    logic                 busy_r;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_serial),
        .q   (rx_s)
    );

    // Start bit is judged half a bit after its falling edge; every later
    // sample is one full bit after the previous one, which keeps it mid-bit.
    assign half_s = (sample_cnt_r == SW'(OVERSAMPLE / 2 - 1));
    assign full_s = (sample_cnt_r == SW'(OVERSAMPLE - 1));

    // FSM state, counters and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            sample_cnt_r <= {SW{1'b0}};
            bit_cnt_r    <= {BW{1'b0}};
            shift_r      <= {DATA_BITS{1'b0}};
            par_en_r     <= 1'b0;
            perr_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            sample_cnt_r <= sample_cnt_nxt;
            bit_cnt_r    <= bit_cnt_nxt;
            shift_r      <= shift_nxt;
            par_en_r     <= par_en_nxt;
            perr_r       <= perr_nxt;
        end
    end

    // Next-state and datapath update; nothing moves without a sample tick.
    always_comb begin
        state_nxt      = state_r;
        sample_cnt_nxt = sample_cnt_r;
        bit_cnt_nxt    = bit_cnt_r;
        shift_nxt      = shift_r;
        par_en_nxt     = par_en_r;
        perr_nxt       = perr_r;
        deliver_s      = 1'b0;
        if (sample_tick) begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt      = START;
                        sample_cnt_nxt = {SW{1'b0}};
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                START: begin
                    if (half_s) begin
                        if (!rx_s) begin
                            state_nxt      = DATA;
                            sample_cnt_nxt = {SW{1'b0}};
                            bit_cnt_nxt    = {BW{1'b0}};
                            par_en_nxt     = parity_en;
                        end else begin
                            // Glitch shorter than half a bit: not a frame.
                            state_nxt = IDLE;
                        end
                    end else begin
                        sample_cnt_nxt = sample_cnt_r + SW'(1);
                    end
                end
                DATA: begin
                    if (full_s) begin
                        sample_cnt_nxt = {SW{1'b0}};
                        shift_nxt      = {rx_s, shift_r[DATA_BITS-1:1]};
                        bit_cnt_nxt    = bit_cnt_r + BW'(1);
                        if (bit_cnt_r == BW'(DATA_BITS - 1)) begin
                            state_nxt = par_en_r ? PARITY : STOP;
                        end else begin
                            state_nxt = DATA;
                        end
                    end else begin
                        sample_cnt_nxt = sample_cnt_r + SW'(1);
                    end
                end
                PARITY: begin
                    if (full_s) begin
                        sample_cnt_nxt = {SW{1'b0}};
                        perr_nxt       = parity_bit(shift_r) ^ rx_s;
                        state_nxt      = STOP;
                    end else begin
                        sample_cnt_nxt = sample_cnt_r + SW'(1);
                    end
                end
                STOP: begin
                    if (full_s) begin
                        sample_cnt_nxt = {SW{1'b0}};
                        deliver_s      = 1'b1;
                        // A low stop bit means the line may be in break; wait
                        // for it to return high so it cannot look like a start.
                        state_nxt      = rx_s ? IDLE : BREAK;
                    end else begin
                        sample_cnt_nxt = sample_cnt_r + SW'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = BREAK;
                    end
                end
                default: begin
                    state_nxt      = IDLE;
                    sample_cnt_nxt = {SW{1'b0}};
                    bit_cnt_nxt    = {BW{1'b0}};
                end
            endcase
        end else begin
            state_nxt = state_r;
        end
    end

    // Registered host-side outputs; data and flags hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_r    <= {DATA_BITS{1'b0}};
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            rx_valid_r <= deliver_s;
            busy_r     <= (state_r != IDLE);
            if (deliver_s) begin
                rx_data_r    <= shift_r;
                parity_err_r <= par_en_r & perr_r;
                frame_err_r  <= ~rx_s;
            end else begin
                rx_data_r    <= rx_data_r;
                parity_err_r <= parity_err_r;
                frame_err_r  <= frame_err_r;
            end
        end
    end

    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule
